gray_sample_decoder: RTL and testbench
======================================

Name: gray_sample_decoder

Overview:
Multi-channel, parametrised Gray-code ADC sample decoder for the front-end sample path. It takes NCH packed Gray-coded samples per valid beat and applies an optional bit-order reversal. Each sample is decoded to binary and emitted in offset-binary or two's-complement format through a 2-stage pipeline with valid tracking. Each channel also counts saturated samples (min/max code) over a fixed window and publishes the count at the end of every window, for AGC and monitoring.

Parameters:
WIDTH, 8, bits per sample.
NCH, 2, number of channels packed on the bus; channel c occupies bits [c*WIDTH +: WIDTH].
BIT_REVERSE, 1, 1 = each input sample arrives LSB-first (bit 0 carries the Gray MSB) and is reversed before decode; 0 = MSB-first.
WIN_LOG2, 16, saturation window length is 2^WIN_LOG2 valid samples.

Ports:
clk  in  1  sample clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat qualifier
in_data  in  NCH*WIDTH  packed Gray-coded samples
fmt_twos  in  1  output format: 1 = two's complement, 0 = offset binary; sampled with in_valid
out_valid  out  1  output beat qualifier
out_data  out  NCH*WIDTH  packed decoded samples
stat_valid  out  1  one-cycle pulse: sat_count updated
sat_count  out  NCH*(WIN_LOG2+1)  per-channel saturated-sample count of the last completed window

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, stat_valid=0, sat_count=0, all pipeline valids, window sample counter and per-channel accumulators = 0.
- Stage 1 (input register): on every clk, v1<=in_valid; if in_valid, capture each channel's sample (reversed if BIT_REVERSE=1) and fmt_twos. Data register holds its value when in_valid=0.
- Stage 2: Gray->binary decode, b[W-1]=g[W-1], b[i]=g[i]^b[i+1]. If fmt_twos captured =1, out = {~b[W-1], b[W-2:0]}; else out = b. out_valid<=v1.
- Latency: exactly 2 clk cycles from in_valid to out_valid. Throughput: 1 beat/cycle, no backpressure. Gaps in in_valid propagate as gaps in out_valid.
- fmt_twos travels with its beat; a mid-stream change affects only beats sampled after the change.
- Saturation: a sample is saturated when its decoded offset-binary value b == 0 or b == 2^WIDTH-1, independent of fmt_twos.
- Window counter (WIN_LOG2 bits) increments on each out_valid beat and wraps to 0 after 2^WIN_LOG2-1.
- Per-channel accumulator (WIN_LOG2+1 bits) increments on saturated out_valid beats. It cannot overflow, because its maximum is 2^WIN_LOG2.
- On the out_valid beat where the window counter = 2^WIN_LOG2-1, the following happens on the next clk edge:
  - sat_count <= accumulator plus this beat's saturation (the closing beat is included);
  - accumulator <= 0;
  - stat_valid <= 1 for exactly one cycle.
- sat_count holds between windows.
- Reset mid-window discards the partial window; the count restarts at 0.
- No internal state depends on out_data consumers.

Decomposition:
- Package gray_dec_pkg: function gray2bin(WIDTH generic via max-width loop), function bitrev, localparam default widths, and the saturation-code constants (all-zeros and all-ones).
- Sub-module gray_chan_decode: one channel's 2-stage data path plus its saturation flag. It is instantiated NCH times in a generate loop.
- Top-level logic: shared valid pipeline, window counter, per-channel accumulators, sat_count/stat_valid registers.

Test Plan:
- WIDTH=8, BIT_REVERSE=1, fmt_twos=1, sweep binary j=0..255 Gray-encoded and bit-reversed (e.g. j=0x80 -> in 0x03; j=0x05 -> in 0xE0) -> out_data j^0x80 (0x00, 0x85), 2 cycles after each in_valid.
- Same sweep with fmt_twos=0 and BIT_REVERSE=0 -> out_data == j; toggle fmt_twos at beat 100 -> beats 0..99 unchanged, beats >= 100 switch format exactly.
- NCH=2, channel 0 = j, channel 1 = 255-j, random in_valid gaps (~30%) -> per-channel outputs correct, out_valid pattern equals in_valid delayed 2 cycles.
- WIN_LOG2=4, 16 beats with codes 0x00 x3, 0xFF x2 (the last beat 0xFF), others mid-scale -> single stat_valid pulse 1 cycle after the 16th out_valid, sat_count=5; next window all mid-scale -> sat_count=0.
- Window of 16 beats, all saturated -> sat_count=16 (no overflow).
- Assert rst_n low after beat 7 of a window with 3 saturated samples -> all outputs 0 immediately; after release, 16 fresh beats with 1 saturated sample -> sat_count=1.

Source files
------------

// File: rtl/gray_dec_pkg.sv
// Shared helpers for the Gray-code sample decoder: Gray->binary decode, bit reversal,
// default sizes and the two saturation codes.
package gray_dec_pkg;

  localparam int MAX_WIDTH    = 32;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_NCH      = 2;
  localparam int DEF_WIN_LOG2 = 16;

  // Saturation codes in offset binary; callers slice to their sample width.
  localparam logic [MAX_WIDTH-1:0] SAT_LO = '0;
  localparam logic [MAX_WIDTH-1:0] SAT_HI = '1;

  // Prefix-XOR from the MSB down: b[i] = ^g[MAX_WIDTH-1:i]. Zero-extended inputs
  // decode correctly for any width up to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < MAX_WIDTH; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  // Reverse the low w bits of a zero-extended value.
  function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] v,
                                                 input int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    r = {<<{v}};
    return r >> (MAX_WIDTH - w);
  endfunction

endpackage

// File: rtl/gray_chan_decode.sv
// One channel of the decoder: input capture, Gray->binary decode with output format
// selection, and a saturation flag aligned with the decoded sample.
module gray_chan_decode
  import gray_dec_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             advance,
  input  logic [WIDTH-1:0] sample,
  input  logic             fmt_twos,
  output logic [WIDTH-1:0] dec,
  output logic             sat
);

  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] g_q;
  logic             fmt_q;
  logic [WIDTH-1:0] b;

  assign g_in = BIT_REVERSE ? WIDTH'(bitrev(MAX_WIDTH'(sample), WIDTH)) : sample;
  assign b    = WIDTH'(gray2bin(MAX_WIDTH'(g_q)));

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its source, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= '0;
      fmt_q <= 1'b0;
    end else if (capture) begin
      g_q   <= g_in;
      fmt_q <= fmt_twos;
    end
  end

  // Saturation is judged on the offset-binary value, whatever the output format.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec <= '0;
      sat <= 1'b0;
    end else if (advance) begin
      dec <= fmt_q ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
      sat <= (b == SAT_LO[WIDTH-1:0]) || (b == SAT_HI[WIDTH-1:0]);
    end
  end

endmodule

// File: rtl/gray_sample_decoder.sv
// Multi-channel Gray-code ADC sample decoder with a 2-stage valid pipeline and
// per-channel saturated-sample counts published once per window.
module gray_sample_decoder
  import gray_dec_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NCH         = DEF_NCH,
  parameter bit BIT_REVERSE = 1'b1,
  parameter int WIN_LOG2    = DEF_WIN_LOG2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [NCH*WIDTH-1:0]      in_data,
  input  logic                      fmt_twos,
  output logic                      out_valid,
  output logic [NCH*WIDTH-1:0]      out_data,
  output logic                      stat_valid,
  output logic [NCH*(WIN_LOG2+1)-1:0] sat_count
);

  localparam int CW = WIN_LOG2 + 1;

  logic                v1;
  logic [NCH-1:0]      sat;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_last;
  logic [CW-1:0]       acc [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    gray_chan_decode #(
      .WIDTH       (WIDTH),
      .BIT_REVERSE (BIT_REVERSE)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .capture  (in_valid),
      .advance  (v1),
      .sample   (in_data[c*WIDTH +: WIDTH]),
      .fmt_twos (fmt_twos),
      .dec      (out_data[c*WIDTH +: WIDTH]),
      .sat      (sat[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  assign win_last = (win_cnt == '1);

  // The closing beat's saturation is folded into the published count, so the
  // accumulator restarts at zero rather than at that beat's flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      stat_valid <= 1'b0;
      sat_count  <= '0;
      // NOTE: the accumulator array is real state that decides the first
      // published count, so it is reset like any other register.
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      stat_valid <= out_valid && win_last;
      if (out_valid) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
        for (int c = 0; c < NCH; c++) begin
          if (win_last) begin
            sat_count[c*CW +: CW] <= acc[c] + CW'(sat[c]);
            acc[c]                <= '0;
          end else begin
            acc[c] <= acc[c] + CW'(sat[c]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_sample_decoder.sv
// Scoreboard bench for gray_sample_decoder: a reversed 2-channel instance with a
// 16-beat window, plus a single-channel MSB-first instance on the same beats.
module tb_gray_sample_decoder;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int WL = 4;
  localparam int CW = WL + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             fmt_twos = 1'b0;
  logic [N*W-1:0]   in_data = '0;
  logic             out_valid;
  logic [N*W-1:0]   out_data;
  logic             stat_valid;
  logic [N*CW-1:0]  sat_count;

  logic [W-1:0]     in_data2 = '0;
  logic             out_valid2;
  logic [W-1:0]     out_data2;
  logic             stat_valid2;
  logic [16:0]      sat_count2;

  always #5 clk = ~clk;

  gray_sample_decoder #(.WIDTH(W), .NCH(N), .BIT_REVERSE(1'b1), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .fmt_twos(fmt_twos), .out_valid(out_valid), .out_data(out_data),
    .stat_valid(stat_valid), .sat_count(sat_count)
  );

  gray_sample_decoder #(.WIDTH(W), .NCH(1), .BIT_REVERSE(1'b0), .WIN_LOG2(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data2),
    .fmt_twos(fmt_twos), .out_valid(out_valid2), .out_data(out_data2),
    .stat_valid(stat_valid2), .sat_count(sat_count2)
  );

  int total = 0;
  int bad   = 0;

  logic [N*W-1:0]  exp_q  [$];
  logic [W-1:0]    exp2_q [$];
  logic [N*CW-1:0] stat_q [$];
  logic [N*W-1:0]  e_data;
  logic [W-1:0]    e_data2;
  logic [N*CW-1:0] e_stat;

  int m_beats = 0;
  int m_sat0  = 0;
  int m_sat1  = 0;

  logic [1:0] vh;
  logic       prev_ov;
  int         obeats;

  function automatic logic [W-1:0] genc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] rev8(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] fmt_val(input logic [W-1:0] b, input logic fmt);
    return fmt ? (b ^ 8'h80) : b;
  endfunction

  // Drive one valid beat (channel 0 = a, channel 1 = c, binary values) and record
  // what the DUTs must produce for it.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] c, input logic fmt);
    in_valid = 1'b1;
    fmt_twos = fmt;
    in_data  = {rev8(genc(c)), rev8(genc(a))};
    in_data2 = genc(a);
    exp_q.push_back({fmt_val(c, fmt), fmt_val(a, fmt)});
    exp2_q.push_back(fmt_val(a, fmt));
    if (a == 8'h00 || a == 8'hFF) m_sat0++;
    if (c == 8'h00 || c == 8'hFF) m_sat1++;
    m_beats++;
    if (m_beats % 16 == 0) begin
      stat_q.push_back({CW'(m_sat1), CW'(m_sat0)});
      m_sat0 = 0;
      m_sat1 = 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    assert (out_valid === 1'b0) else begin
      bad++; $error("FAIL %s out_valid got=%b want=0", tag, out_valid);
    end
    total++;
    assert (out_data === '0) else begin
      bad++; $error("FAIL %s out_data got=%h want=0", tag, out_data);
    end
    total++;
    assert (stat_valid === 1'b0) else begin
      bad++; $error("FAIL %s stat_valid got=%b want=0", tag, stat_valid);
    end
    total++;
    assert (sat_count === '0) else begin
      bad++; $error("FAIL %s sat_count got=%h want=0", tag, sat_count);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      vh      = '0;
      prev_ov = 1'b0;
      obeats  = 0;
    end else begin
      total++;
      assert (out_valid === vh[1]) else begin
        bad++; $error("FAIL valid_align got=%b want=%b", out_valid, vh[1]);
      end
      if (stat_valid) begin
        total++;
        assert (prev_ov && obeats > 0 && obeats % 16 == 0) else begin
          bad++; $error("FAIL stat_timing got beats=%0d prev_ov=%b want 16k beats, prev_ov=1",
                        obeats, prev_ov);
        end
        total++;
        assert (stat_q.size() != 0) else begin
          bad++; $error("FAIL stat_spurious got stat_valid=1 want=0");
        end
        if (stat_q.size() != 0) begin
          e_stat = stat_q.pop_front();
          total++;
          assert (sat_count === e_stat) else begin
            bad++; $error("FAIL sat_count got=%h want=%h", sat_count, e_stat);
          end
        end
      end
      if (out_valid) begin
        obeats++;
        total++;
        assert (exp_q.size() != 0) else begin
          bad++; $error("FAIL out_spurious got out_valid=1 want=0");
        end
        if (exp_q.size() != 0) begin
          e_data = exp_q.pop_front();
          total++;
          assert (out_data === e_data) else begin
            bad++; $error("FAIL out_data got=%h want=%h", out_data, e_data);
          end
        end
      end
      if (out_valid2) begin
        total++;
        assert (exp2_q.size() != 0) else begin
          bad++; $error("FAIL out2_spurious got out_valid=1 want=0");
        end
        if (exp2_q.size() != 0) begin
          e_data2 = exp2_q.pop_front();
          total++;
          assert (out_data2 === e_data2) else begin
            bad++; $error("FAIL out2_data got=%h want=%h", out_data2, e_data2);
          end
        end
      end
      prev_ov = out_valid;
      vh      = {vh[0], in_valid};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full code sweep, two's complement, back to back.
    for (int j = 0; j < 256; j++) beat(W'(j), W'(255 - j), 1'b1);

    // Sweep with ~30% gaps; format switches from offset binary at beat 100.
    for (int j = 0; j < 256; j++) begin
      if ($urandom_range(99) < 30) idle(1);
      beat(W'(j), W'(255 - j), (j >= 100) ? 1'b1 : 1'b0);
    end
    idle(4);

    // Window with 5 saturated codes on channel 0, closing on a saturated beat.
    for (int i = 0; i < 16; i++) begin
      beat((i < 3) ? 8'h00 : ((i == 7 || i == 15) ? 8'hFF : W'(8'h40 + i)), 8'h70, 1'b0);
    end
    // Window with no saturation.
    for (int i = 0; i < 16; i++) beat(W'(8'h30 + i), 8'h90, 1'b1);
    // Fully saturated window on both channels.
    for (int i = 0; i < 16; i++) beat((i % 2 == 1) ? 8'hFF : 8'h00, 8'hFF, 1'b0);
    idle(4);

    // Partial window (3 saturated) discarded by a mid-window reset.
    for (int i = 0; i < 7; i++) beat((i == 1 || i == 3 || i == 5) ? 8'h00 : 8'h50, 8'h60, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    exp2_q.delete();
    stat_q.delete();
    m_beats = 0;
    m_sat0  = 0;
    m_sat1  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) beat((i == 9) ? 8'h00 : 8'h60, 8'h20, 1'b0);
    idle(6);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL drain_out got=%0d pending want=0", exp_q.size());
    end
    total++;
    assert (exp2_q.size() == 0) else begin
      bad++; $error("FAIL drain_out2 got=%0d pending want=0", exp2_q.size());
    end
    total++;
    assert (stat_q.size() == 0) else begin
      bad++; $error("FAIL drain_stat got=%0d pending want=0", stat_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
